// File: rtl/pc_sequencer.sv
// Fetch / next-PC controller: owns the PC, fetches over a req/ack handshake,
// hands the instruction to the datapath and picks the next PC on exec_done.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             exec_done,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             jr,
  input  logic [31:0]      immi,
  input  logic [31:0]      jr_addr,
  input  logic             halt,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC, S_HALT} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic             r_inst_valid;
  logic             r_req;
  logic [CNT_W-1:0] r_retired;
  logic             r_halted;
  logic             r_fetch_err;

  logic        w_done_ok;
  logic [31:0] w_pc_plus_4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_next;
  logic        w_unused_immi;

  // exec_done is not accepted while inst_valid is still high (first EXEC cycle)
  assign w_done_ok    = (r_state == S_EXEC) && exec_done && !r_inst_valid;
  assign w_pc_plus_4  = r_pc + 32'd4;
  assign w_branch_tgt = w_pc_plus_4 + {immi[29:0], 2'b00};
  assign w_jump_tgt   = {w_pc_plus_4[31:28], r_inst[25:0], 2'b00};

  always_comb begin
    w_next = w_pc_plus_4;
    if (jr)
      w_next = jr_addr;
    else if (jump)
      w_next = w_jump_tgt;
    else if (branch && zero)
      w_next = w_branch_tgt;
  end

  assign w_unused_immi = ^immi[31:30];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_inst_valid <= 1'b0;
      r_req        <= 1'b0;
      r_retired    <= '0;
      r_halted     <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else begin
      r_inst_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            r_inst       <= imem_rdata;
            r_inst_valid <= 1'b1;
            r_req        <= 1'b0;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_done_ok) begin
            r_retired <= r_retired + CNT_W'(1);
            // a misaligned target never reaches the PC; it stops the core
            if (w_next[1:0] != 2'b00) begin
              r_fetch_err <= 1'b1;
              r_halted    <= 1'b1;
              r_state     <= S_HALT;
            end else begin
              r_pc <= w_next;
              if (halt) begin
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end else begin
                r_req   <= 1'b1;
                r_state <= S_REQ;
              end
            end
          end
        end
        S_HALT: begin
          r_req <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign pc         = r_pc;
  assign retired    = r_retired;
  assign halted     = r_halted;
  assign fetch_err  = r_fetch_err;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/next-PC controller for the MIPS core. It owns the PC register and issues instruction-memory requests over a req/ack handshake. It hands the fetched instruction to the datapath, then waits for the datapath's execute-complete strobe and selects the next PC from four sources: pc+4, branch, jump, or jr. It also detects misaligned targets and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (equals pc)
imem_ack  in  1  memory returns instruction this cycle
imem_rdata  in  32  instruction word, valid when imem_ack
inst  out  32  latched instruction for datapath
inst_valid  out  1  one-cycle pulse: inst newly valid
exec_done  in  1  datapath finished current instruction; control inputs below sampled this cycle
branch  in  1  instruction is conditional branch
zero  in  1  ALU zero flag
jump  in  1  instruction is j/jal
jr  in  1  instruction is jr
immi  in  32  sign-extended 16-bit immediate
jr_addr  in  32  register target for jr
halt  in  1  stop after current instruction
pc  out  32  current PC
retired  out  CNT_W  count of completed instructions
halted  out  1  sequencer in HALT state
fetch_err  out  1  sticky: misaligned next-PC target detected

Behaviour:
- Reset (sync, rst high at clk edge, from any state, including mid-handshake): state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, retired=0, halted=0, fetch_err=0. Any pending ack is discarded.
- States: IDLE, REQ, EXEC, HALT.
- IDLE: one cycle, imem_req=0 -> REQ.
- REQ: imem_req=1, imem_addr=pc, held stable until ack. On imem_ack: inst<=imem_rdata, inst_valid<=1 for the next cycle only, -> EXEC. No ack means stay in REQ indefinitely.
- EXEC: imem_req=0; inst held stable. exec_done is ignored in the cycle inst_valid is high (first EXEC cycle); this gives a minimum of 1 cycle between inst_valid and the accepted done. On accepted exec_done:
  - pc_plus_4 = pc + 4, modulo 2^32.
  - branch_tgt = pc_plus_4 + {immi[29:0],2'b00}, modulo 2^32.
  - jump_tgt = {pc_plus_4[31:28], inst[25:0], 2'b00}.
  - next = jr ? jr_addr : jump ? jump_tgt : (branch & zero) ? branch_tgt : pc_plus_4. Priority is jr > jump > branch; simultaneous flags resolve by this priority.
  - retired <= retired + 1, wrapping.
  - If next[1:0] != 0: pc unchanged, fetch_err<=1, -> HALT.
  - Else pc<=next. If halt -> HALT, else -> REQ.
- HALT: imem_req=0, halted=1, pc and retired frozen. Left only via rst.
- halt outside an accepted exec_done is ignored (not latched).
- imem_ack outside REQ is ignored.
- Latency: an ack at cycle t gives inst_valid at t+1. The earliest accepted exec_done is at t+2. imem_req is reasserted at t+3 with the new pc.

Test Plan:
- Reset/sequential: rst 1 cycle. Expect pc=0x3000, imem_req high 2 cycles later. Ack with 0x00000000, exec_done with all flags 0 -> next request addr 0x3004, retired=1.
- Branch taken/not: pc=0x3004, branch=1, immi=0xFFFFFFFE. zero=1 -> pc=0x3000; zero=0 -> pc=0x3008.
- Jump and priority: pc=0x3000, inst=0x08000C10, jump=1 -> pc=0x00003040. Same with jr=1, jr_addr=0x4000 and branch=1, zero=1 asserted -> pc=0x4000.
- Misaligned/halt: jr_addr=0x4002 -> fetch_err=1, halted=1, pc stays 0x3000, no further imem_req. Separately, halt=1 with exec_done -> pc updated, then halted=1.
- Handshake stall: hold imem_ack low 5 cycles -> imem_req and imem_addr stable throughout; ack on cycle 6 -> inst_valid exactly one cycle; exec_done in the inst_valid cycle is ignored.
- Reset mid-operation and wrap: rst asserted in EXEC -> all outputs at reset values next cycle. Also force pc=0xFFFFFFFC with plain advance -> pc=0x00000000.
